snake_tick_controller: RTL and testbench
========================================

SNAKE_TICK_CONTROLLER -- requirements
Module: snake_tick_controller

Parameters
REQ-001 The block SHALL have parameter X_MAX, default 159: largest legal x coordinate.
REQ-002 The block SHALL have parameter Y_MAX, default 119: largest legal y coordinate.
REQ-003 The block SHALL have parameter INIT_LEN, default 4: snake length after reset, range 2..16.
REQ-004 The block SHALL have parameter MAX_LEN, default 2048: maximum segment count, equal to the RAM depth.

Interface
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port game_tick, input, 1 bit: one-cycle pulse that starts one move.
REQ-008 The block SHALL have port dir, input, 2 bits: requested direction; 00 up, 01 down, 10 left, 11 right.
REQ-009 The block SHALL have ports food_x, input, 8 bits, and food_y, input, 7 bits: current food position.
REQ-010 The block SHALL have port ram_q, input, 17 bits: RAM read data, {x[16:9], y[8:2], type[1:0]}, valid 1 cycle after the address is presented.
REQ-011 The block SHALL have ports ram_address, output, 11 bits; ram_wren, output, 1 bit; ram_data, output, 17 bits: the segment RAM port.
REQ-012 The block SHALL have ports x_out, output, 8 bits; y_out, output, 7 bits; plot, output, 1 bit; colour, output, 3 bits: the pixel draw request.
REQ-013 The block SHALL have ports status, output, 2 bits (00 init, 01 running, 10 wall hit, 11 full); food_eaten, output, 1-cycle pulse; busy, output, 1 bit.

Function
REQ-014 The segment RAM SHALL be used as a circular buffer holding the segment entries between tail_ptr and head_ptr; pointer increments SHALL wrap modulo 2048.
REQ-015 In INIT, the block SHALL write INIT_LEN entries, one per cycle, at addresses 0..INIT_LEN-1, segment i at x=80-INIT_LEN+1+i, y=60, type 01, asserting plot with colour 010 for each entry in the same cycle; it SHALL then set head_ptr=INIT_LEN-1, tail_ptr=0, length=INIT_LEN, status=01, and move to IDLE.
REQ-016 The states SHALL be INIT, IDLE, RD_HEAD, WAIT_HEAD, CALC, WR_HEAD, PLOT_HEAD, RD_TAIL, WAIT_TAIL, PLOT_TAIL and OVER.
REQ-017 busy SHALL be 0 only in IDLE and OVER.
REQ-018 In IDLE, a game_tick SHALL move the block to RD_HEAD; game_tick SHALL be ignored in all other states, with no queueing.
REQ-019 dir SHALL be sampled only on the accepted tick; a request opposite to the current direction SHALL be discarded, keeping the current direction (reset direction: right).
REQ-020 RD_HEAD SHALL drive ram_address=head_ptr with ram_wren=0; WAIT_HEAD SHALL capture ram_q.
REQ-021 CALC SHALL compute the new head as the head ±1 in x or y, without wrap.
REQ-022 If the move would leave the range 0..X_MAX or 0..Y_MAX, the block SHALL set status=10 and go to OVER with no RAM write.
REQ-023 A new head equal to {food_x, food_y} SHALL be an eat.
REQ-024 On an eat with length==MAX_LEN, the block SHALL set status=11 and go to OVER.
REQ-025 WR_HEAD SHALL drive ram_address=head_ptr+1, ram_wren=1 for exactly that cycle, and ram_data={new_x, new_y, 01}; head_ptr SHALL then increment.
REQ-026 PLOT_HEAD SHALL assert plot for 1 cycle with the new head coordinates and colour 010.
REQ-027 After PLOT_HEAD, on an eat the block SHALL pulse food_eaten, increment length, and return to IDLE without erasing the tail.
REQ-028 After PLOT_HEAD with no eat, the block SHALL go to RD_TAIL (ram_address=tail_ptr), then WAIT_TAIL, then PLOT_TAIL.
REQ-029 PLOT_TAIL SHALL assert plot with the x,y from ram_q and colour 000, and SHALL increment tail_ptr.
REQ-030 A non-eat move SHALL take exactly 9 cycles from the tick to the return to IDLE; an eat move SHALL take 6 cycles.
REQ-031 ram_wren and plot SHALL be 0 in every state not listed above as driving them.
REQ-032 OVER SHALL be terminal until reset_n is asserted.

Reset
REQ-033 reset_n low SHALL immediately force state=INIT, status=00, all pointers and length=0, plot=0, ram_wren=0, food_eaten=0, ram_address=0, x_out=0, y_out=0, colour=000, and direction=right.
REQ-034 Reset asserted mid-move SHALL abandon the move with no further RAM writes.
REQ-035 After reset is released, the block SHALL run INIT and reach IDLE INIT_LEN+1 cycles later.

Verification
REQ-036 The bench SHALL check: reset release -> 4 write+plot cycles at (77..80,60), colour 010, then status=01 and busy=0.
REQ-037 The bench SHALL check: tick with dir=11, food elsewhere -> write at address 4 of (81,60); plot at (81,60) colour 010; plot at (77,60) colour 000; 9 cycles total.
REQ-038 The bench SHALL check: tick with dir=10 while moving right -> reversal ignored, head written at (81,60).
REQ-039 The bench SHALL check: food at (81,60), tick -> food_eaten pulses, no tail erase, length=5, 6 cycles.
REQ-040 The bench SHALL check: head at x=159 moving right, tick -> status=10, no ram_wren, later ticks ignored.
REQ-041 The bench SHALL check: reset asserted in WR_HEAD -> ram_wren drops immediately, and the block re-runs INIT.

Source files
------------

// File: rtl/snake_tick_controller.sv
// Snake game move sequencer: keeps the body in an external segment RAM used as a
// ring buffer, advances the head on each accepted game tick and erases the tail.
module snake_tick_controller #(
  parameter int X_MAX    = 159,
  parameter int Y_MAX    = 119,
  parameter int INIT_LEN = 4,
  parameter int MAX_LEN  = 2048
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        game_tick,
  input  logic [1:0]  dir,
  input  logic [7:0]  food_x,
  input  logic [6:0]  food_y,
  input  logic [16:0] ram_q,
  output logic [10:0] ram_address,
  output logic        ram_wren,
  output logic [16:0] ram_data,
  output logic [7:0]  x_out,
  output logic [6:0]  y_out,
  output logic        plot,
  output logic [2:0]  colour,
  output logic [1:0]  status,
  output logic        food_eaten,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_INIT,
    S_IDLE,
    S_RD_HEAD,
    S_WAIT_HEAD,
    S_CALC,
    S_WR_HEAD,
    S_PLOT_HEAD,
    S_RD_TAIL,
    S_WAIT_TAIL,
    S_PLOT_TAIL,
    S_OVER
  } state_t;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam logic [1:0] ST_INIT = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_WALL = 2'b10;
  localparam logic [1:0] ST_FULL = 2'b11;

  localparam logic [1:0] SEG_BODY  = 2'b01;
  localparam logic [2:0] COL_SNAKE = 3'b010;
  localparam logic [2:0] COL_BG    = 3'b000;

  localparam int INIT_X0 = 81 - INIT_LEN;
  localparam int INIT_Y  = 60;

  state_t      state_reg, state_next;
  logic [10:0] head_ptr_reg, head_ptr_next;
  logic [10:0] tail_ptr_reg, tail_ptr_next;
  logic [11:0] length_reg, length_next;
  logic [1:0]  dir_reg, dir_next;
  logic [1:0]  status_reg, status_next;
  logic [4:0]  init_cnt_reg, init_cnt_next;
  logic [7:0]  head_x_reg, head_x_next;
  logic [6:0]  head_y_reg, head_y_next;
  logic [7:0]  new_x_reg, new_x_next;
  logic [6:0]  new_y_reg, new_y_next;
  logic        eat_reg, eat_next;

  logic [10:0] ram_address_reg, ram_address_next;
  logic        ram_wren_reg, ram_wren_next;
  logic [16:0] ram_data_reg, ram_data_next;
  logic [7:0]  x_out_reg, x_out_next;
  logic [6:0]  y_out_reg, y_out_next;
  logic        plot_reg, plot_next;
  logic [2:0]  colour_reg, colour_next;
  logic        food_eaten_reg, food_eaten_next;

  logic [7:0]  init_x;
  logic [7:0]  move_x;
  logic [6:0]  move_y;
  logic        wall_hit;
  logic        move_eat;
  logic        ram_type_unused;

  // The segment type field is only written, never needed on read-back.
  assign ram_type_unused = ^ram_q[1:0];

  assign init_x = 8'(INIT_X0) + {3'b000, init_cnt_reg};

  // Candidate head one step away from the stored head; no wrap at the borders.
  always_comb begin
    move_x   = head_x_reg;
    move_y   = head_y_reg;
    wall_hit = 1'b0;
    case (dir_reg)
      DIR_UP: begin
        if (head_y_reg == 7'd0) wall_hit = 1'b1;
        else                    move_y   = head_y_reg - 7'd1;
      end
      DIR_DOWN: begin
        if ({1'b0, head_y_reg} >= 8'(Y_MAX)) wall_hit = 1'b1;
        else                                 move_y   = head_y_reg + 7'd1;
      end
      DIR_LEFT: begin
        if (head_x_reg == 8'd0) wall_hit = 1'b1;
        else                    move_x   = head_x_reg - 8'd1;
      end
      default: begin
        if ({1'b0, head_x_reg} >= 9'(X_MAX)) wall_hit = 1'b1;
        else                                 move_x   = head_x_reg + 8'd1;
      end
    endcase
  end

  assign move_eat = (move_x == food_x) && (move_y == food_y);

  always_comb begin
    state_next       = state_reg;
    head_ptr_next    = head_ptr_reg;
    tail_ptr_next    = tail_ptr_reg;
    length_next      = length_reg;
    dir_next         = dir_reg;
    status_next      = status_reg;
    init_cnt_next    = init_cnt_reg;
    head_x_next      = head_x_reg;
    head_y_next      = head_y_reg;
    new_x_next       = new_x_reg;
    new_y_next       = new_y_reg;
    eat_next         = eat_reg;
    ram_address_next = ram_address_reg;
    ram_data_next    = ram_data_reg;
    x_out_next       = x_out_reg;
    y_out_next       = y_out_reg;
    colour_next      = colour_reg;
    ram_wren_next    = 1'b0;
    plot_next        = 1'b0;
    food_eaten_next  = 1'b0;

    // Outputs are registered, so each branch loads what the *next* state drives.
    case (state_reg)
      S_INIT: begin
        if (init_cnt_reg < 5'(INIT_LEN)) begin
          ram_address_next = 11'(init_cnt_reg);
          ram_wren_next    = 1'b1;
          ram_data_next    = {init_x, 7'(INIT_Y), SEG_BODY};
          plot_next        = 1'b1;
          x_out_next       = init_x;
          y_out_next       = 7'(INIT_Y);
          colour_next      = COL_SNAKE;
          init_cnt_next    = init_cnt_reg + 5'd1;
        end else begin
          head_ptr_next = 11'(INIT_LEN - 1);
          tail_ptr_next = 11'd0;
          length_next   = 12'(INIT_LEN);
          status_next   = ST_RUN;
          state_next    = S_IDLE;
        end
      end

      S_IDLE: begin
        if (game_tick) begin
          // A request for the exact reverse direction differs only in bit 0.
          if (dir != (dir_reg ^ 2'b01)) dir_next = dir;
          ram_address_next = head_ptr_reg;
          state_next       = S_RD_HEAD;
        end
      end

      S_RD_HEAD: state_next = S_WAIT_HEAD;

      S_WAIT_HEAD: begin
        head_x_next = ram_q[16:9];
        head_y_next = ram_q[8:2];
        state_next  = S_CALC;
      end

      S_CALC: begin
        if (wall_hit) begin
          status_next = ST_WALL;
          state_next  = S_OVER;
        end else if (move_eat && (length_reg == 12'(MAX_LEN))) begin
          status_next = ST_FULL;
          state_next  = S_OVER;
        end else begin
          new_x_next       = move_x;
          new_y_next       = move_y;
          eat_next         = move_eat;
          ram_address_next = head_ptr_reg + 11'd1;
          ram_wren_next    = 1'b1;
          ram_data_next    = {move_x, move_y, SEG_BODY};
          head_ptr_next    = head_ptr_reg + 11'd1;
          state_next       = S_WR_HEAD;
        end
      end

      S_WR_HEAD: begin
        plot_next   = 1'b1;
        x_out_next  = new_x_reg;
        y_out_next  = new_y_reg;
        colour_next = COL_SNAKE;
        state_next  = S_PLOT_HEAD;
      end

      S_PLOT_HEAD: begin
        if (eat_reg) begin
          food_eaten_next = 1'b1;
          length_next     = length_reg + 12'd1;
          state_next      = S_IDLE;
        end else begin
          ram_address_next = tail_ptr_reg;
          state_next       = S_RD_TAIL;
        end
      end

      S_RD_TAIL: state_next = S_WAIT_TAIL;

      S_WAIT_TAIL: begin
        plot_next     = 1'b1;
        x_out_next    = ram_q[16:9];
        y_out_next    = ram_q[8:2];
        colour_next   = COL_BG;
        tail_ptr_next = tail_ptr_reg + 11'd1;
        state_next    = S_PLOT_TAIL;
      end

      S_PLOT_TAIL: state_next = S_IDLE;

      S_OVER: state_next = S_OVER;

      default: state_next = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= S_INIT;
      head_ptr_reg    <= '0;
      tail_ptr_reg    <= '0;
      length_reg      <= '0;
      dir_reg         <= DIR_RIGHT;
      status_reg      <= ST_INIT;
      init_cnt_reg    <= '0;
      head_x_reg      <= '0;
      head_y_reg      <= '0;
      new_x_reg       <= '0;
      new_y_reg       <= '0;
      eat_reg         <= 1'b0;
      ram_address_reg <= '0;
      ram_wren_reg    <= 1'b0;
      ram_data_reg    <= '0;
      x_out_reg       <= '0;
      y_out_reg       <= '0;
      plot_reg        <= 1'b0;
      colour_reg      <= COL_BG;
      food_eaten_reg  <= 1'b0;
    end else begin
      state_reg       <= state_next;
      head_ptr_reg    <= head_ptr_next;
      tail_ptr_reg    <= tail_ptr_next;
      length_reg      <= length_next;
      dir_reg         <= dir_next;
      status_reg      <= status_next;
      init_cnt_reg    <= init_cnt_next;
      head_x_reg      <= head_x_next;
      head_y_reg      <= head_y_next;
      new_x_reg       <= new_x_next;
      new_y_reg       <= new_y_next;
      eat_reg         <= eat_next;
      ram_address_reg <= ram_address_next;
      ram_wren_reg    <= ram_wren_next;
      ram_data_reg    <= ram_data_next;
      x_out_reg       <= x_out_next;
      y_out_reg       <= y_out_next;
      plot_reg        <= plot_next;
      colour_reg      <= colour_next;
      food_eaten_reg  <= food_eaten_next;
    end
  end

  assign ram_address = ram_address_reg;
  assign ram_wren    = ram_wren_reg;
  assign ram_data    = ram_data_reg;
  assign x_out       = x_out_reg;
  assign y_out       = y_out_reg;
  assign plot        = plot_reg;
  assign colour      = colour_reg;
  assign status      = status_reg;
  assign food_eaten  = food_eaten_reg;
  assign busy        = (state_reg != S_IDLE) && (state_reg != S_OVER);

endmodule

// File: tb/tb_snake_tick_controller.sv
// Scoreboard bench for snake_tick_controller: a queue-based snake model predicts
// RAM writes, plots and food pulses; a negedge monitor matches them as they appear.
module tb_snake_tick_controller;

  localparam int X_MAX    = 159;
  localparam int Y_MAX    = 119;
  localparam int INIT_LEN = 4;
  localparam int MAX_LEN  = 2048;

  logic        clk;
  logic        reset_n;
  logic        game_tick;
  logic [1:0]  dir;
  logic [7:0]  food_x;
  logic [6:0]  food_y;
  logic [16:0] ram_q;
  logic [10:0] ram_address;
  logic        ram_wren;
  logic [16:0] ram_data;
  logic [7:0]  x_out;
  logic [6:0]  y_out;
  logic        plot;
  logic [2:0]  colour;
  logic [1:0]  status;
  logic        food_eaten;
  logic        busy;

  snake_tick_controller #(
    .X_MAX(X_MAX), .Y_MAX(Y_MAX), .INIT_LEN(INIT_LEN), .MAX_LEN(MAX_LEN)
  ) dut (
    .clk(clk), .reset_n(reset_n), .game_tick(game_tick), .dir(dir),
    .food_x(food_x), .food_y(food_y), .ram_q(ram_q),
    .ram_address(ram_address), .ram_wren(ram_wren), .ram_data(ram_data),
    .x_out(x_out), .y_out(y_out), .plot(plot), .colour(colour),
    .status(status), .food_eaten(food_eaten), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Segment RAM with one-cycle registered read.
  logic [16:0] mem [0:2047];
  always @(posedge clk) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  // kind: 0 = RAM write (c holds type), 1 = plot (c holds colour), 2 = food pulse
  typedef struct {
    int kind;
    int addr;
    int x;
    int y;
    int c;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  fails  = 0;

  // Reference snake: body coordinates tail-first, plus direction and head slot.
  int bx[$];
  int by[$];
  int mdir;
  int mhead;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_ev(input int kind, input int addr, input int x, input int y, input int c);
    ev_t e;
    e.kind = kind; e.addr = addr; e.x = x; e.y = y; e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic match_event(input int kind, input int addr, input int x, input int y, input int c);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      fails++;
      $display("FAIL unexpected_event: got kind=%0d addr=%0d x=%0d y=%0d c=%0d, required none (t=%0t)",
               kind, addr, x, y, c, $time);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      if (kind == e.kind) begin
        if (kind == 0) check("write_addr", addr, e.addr);
        if (kind != 2) begin
          check("event_x", x, e.x);
          check("event_y", y, e.y);
          check(kind == 0 ? "write_type" : "plot_colour", c, e.c);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (ram_wren) match_event(0, int'(ram_address), int'(ram_data[16:9]), int'(ram_data[8:2]), int'(ram_data[1:0]));
    if (plot) match_event(1, 0, int'(x_out), int'(y_out), int'(colour));
    if (food_eaten) match_event(2, 0, 0, 0, 0);
  end

  task automatic model_reset();
    bx.delete();
    by.delete();
    mdir  = 3;
    mhead = INIT_LEN - 1;
    for (int i = 0; i < INIT_LEN; i++) begin
      bx.push_back(80 - INIT_LEN + 1 + i);
      by.push_back(60);
      push_ev(0, i, 80 - INIT_LEN + 1 + i, 60, 1);
      push_ev(1, 0, 80 - INIT_LEN + 1 + i, 60, 2);
    end
  endtask

  task automatic predict(input int d, output int eff, output int nx, output int ny);
    eff = (d == (mdir ^ 1)) ? mdir : d;
    nx  = bx[$];
    ny  = by[$];
    case (eff)
      0: ny = ny - 1;
      1: ny = ny + 1;
      2: nx = nx - 1;
      default: nx = nx + 1;
    endcase
  endtask

  // result: 0 plain move, 1 eat, 2 wall, 3 full
  task automatic model_move(input int d, input int fx, input int fy, output int result);
    int eff, nx, ny;
    predict(d, eff, nx, ny);
    mdir = eff;
    if (nx < 0 || nx > X_MAX || ny < 0 || ny > Y_MAX) begin
      result = 2;
    end else if (nx == fx && ny == fy && bx.size() == MAX_LEN) begin
      result = 3;
    end else begin
      mhead = (mhead + 1) % 2048;
      push_ev(0, mhead, nx, ny, 1);
      push_ev(1, 0, nx, ny, 2);
      bx.push_back(nx);
      by.push_back(ny);
      if (nx == fx && ny == fy) begin
        push_ev(2, 0, 0, 0, 0);
        result = 1;
      end else begin
        push_ev(1, 0, bx[0], by[0], 0);
        void'(bx.pop_front());
        void'(by.pop_front());
        result = 0;
      end
    end
  endtask

  // Releases reset on a negedge and counts cycles until INIT finishes.
  task automatic run_init();
    int n;
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 30);
    check("init_cycles", n, INIT_LEN + 1);
    check("init_status", int'(status), 1);
    check("init_busy", int'(busy), 0);
    $display("init done after %0d cycles, status=%0d", n, status);
  endtask

  // Starts on a negedge with the DUT idle and returns on the negedge it is idle again.
  task automatic do_move(input int d, input int fx, input int fy, input bit noisy);
    int result, n;
    dir       = 2'(d);
    food_x    = 8'(fx);
    food_y    = 7'(fy);
    game_tick = 1'b1;
    model_move(d, fx, fy, result);
    n = 1;
    @(negedge clk);
    game_tick = 1'b0;
    while (busy && n < 40) begin
      if (noisy) begin
        game_tick = ($urandom_range(0, 2) == 0);
        dir       = 2'($urandom_range(0, 3));
      end
      n++;
      @(negedge clk);
    end
    game_tick = 1'b0;
    if (busy) check("move_timeout_busy", int'(busy), 0);
    if (result == 0) begin
      check("move_cycles", n, 9);
      check("move_status", int'(status), 1);
    end else if (result == 1) begin
      check("eat_cycles", n, 6);
      check("eat_status", int'(status), 1);
    end else begin
      check("over_status", int'(status), result);
    end
    $display("move dir=%0d food=(%0d,%0d) result=%0d cycles=%0d len=%0d", d, fx, fy, result, n, bx.size());
  endtask

  initial begin
    int eff, nx, ny, d, fx, fy, r;
    reset_n   = 1'b1;
    game_tick = 1'b0;
    dir       = 2'b00;
    food_x    = 8'd0;
    food_y    = 7'd0;
    #1 reset_n = 1'b0;

    @(negedge clk);
    check("rst_status", int'(status), 0);
    check("rst_wren", int'(ram_wren), 0);
    check("rst_plot", int'(plot), 0);
    check("rst_addr", int'(ram_address), 0);
    check("rst_colour", int'(colour), 0);
    check("rst_busy", int'(busy), 1);
    model_reset();
    run_init();

    // Reverse request while heading right, then an eat straight ahead.
    do_move(2, 0, 0, 1'b0);
    do_move(3, 82, 60, 1'b0);

    for (int i = 0; i < 40; i++) begin
      d = $urandom_range(0, 3);
      predict(d, eff, nx, ny);
      if ($urandom_range(0, 2) == 0) begin
        fx = nx; fy = ny;
      end else begin
        fx = $urandom_range(0, X_MAX); fy = $urandom_range(0, Y_MAX);
      end
      do_move(d, fx, fy, 1'b1);
    end

    // Reset landing in the head-write cycle.
    dir = 2'd3; food_x = 8'd0; food_y = 7'd0; game_tick = 1'b1;
    model_move(3, 0, 0, r);
    r = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      game_tick = 1'b0;
      if (ram_wren) break;
    end
    check("wr_head_seen", int'(ram_wren), 1);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_wren", int'(ram_wren), 0);
    check("midrst_plot", int'(plot), 0);
    check("midrst_status", int'(status), 0);
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    run_init();

    // March to the right border, then one step past it.
    for (int i = 0; i < X_MAX - 80; i++) do_move(3, 0, 0, 1'b0);
    check("at_border_x", bx[$], X_MAX);
    do_move(3, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      game_tick = 1'b1;
      @(negedge clk);
      game_tick = 1'b0;
      @(negedge clk);
      check("over_busy", int'(busy), 0);
      check("over_hold", int'(status), 2);
    end
    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
